// File: rtl/xform_decode.sv
// xform_decode: inverts enc = ~x + OFFSET through a 2-entry skid buffer with a saturating transfer counter
module xform_decode #(
  parameter int WIDTH  = 8,
  parameter int OFFSET = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      byte_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] skid, dec;
  logic in_xfer, out_xfer, load_main, load_skid, shift_skid;
  assign dec       = ~(in_data - WIDTH'(OFFSET));
  assign out_valid = state != EMPTY;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // next state and which register captures the decoded word
  always_comb begin
    state_nx   = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state)
      EMPTY: begin
        state_nx  = in_xfer ? ONE : EMPTY;
        load_main = in_xfer;
      end
      ONE: begin
        state_nx  = (in_xfer && !out_xfer) ? TWO : (out_xfer && !in_xfer) ? EMPTY : ONE;
        load_main = in_xfer && out_xfer;
        load_skid = in_xfer && !out_xfer;
      end
      TWO: begin
        state_nx   = out_xfer ? ONE : TWO;
        shift_skid = out_xfer;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // buffer registers, registered ready and saturating output transfer count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      out_data <= '0;
      skid     <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != TWO;
      if (load_main) out_data <= dec;
      if (shift_skid) out_data <= skid;
      if (load_skid) skid <= dec;
      if (out_xfer && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_xform_decode.sv
// tb_xform_decode: random and directed stimulus checked against a queue-based model of the decoder
module tb_xform_decode;
  localparam int W = 8;
  localparam int OFF = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [15:0] byte_cnt;
  int total = 0;
  int bad = 0;
  xform_decode #(.WIDTH(W), .OFFSET(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .byte_cnt(byte_cnt)
  );
  always #5 clk = ~clk;
  logic [W-1:0] q[$];
  int unsigned mcnt = 0;
  bit up = 0;
  bit p_in = 0;
  bit p_out = 0;
  bit stall = 0;
  bit exp_v;
  logic [W-1:0] p_data, hold_data;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model state update: transfers predicted at the previous falling edge take effect here
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      up = 0;
      p_in = 0;
      p_out = 0;
      stall = 0;
    end else begin
      if (p_out) begin
        void'(q.pop_front());
        if (mcnt != 32'hFFFF) mcnt++;
      end
      if (p_in) q.push_back(p_data);
      up = 1;
      p_in = 0;
      p_out = 0;
    end
  end
  // compare DUT against the model every cycle and predict the next edge's transfers
  always @(negedge clk) begin
    exp_v = q.size() > 0;
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("in_ready", 32'(in_ready), 32'(up && q.size() < 2));
    chk("byte_cnt", 32'(byte_cnt), mcnt);
    if (exp_v) chk("out_data", 32'(out_data), 32'(q[0]));
    else if (!rst_n) chk("rst_out_data", 32'(out_data), 32'h0);
    if (stall) chk("stall_hold", 32'(out_data), 32'(hold_data));
    if (rst_n) begin
      p_in = in_valid && up && q.size() < 2;
      p_data = ~in_data + W'(OFF);
      p_out = exp_v && out_ready;
      stall = exp_v && !out_ready;
      hold_data = out_data;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 0;
    out_ready = 0;
    rst_n = 0;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_cnt", 32'(byte_cnt), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst_n = 1;
    chk("rst_ready", 32'(in_ready), 32'h0);
    step();
    chk("ready_rise", 32'(in_ready), 32'h1);
  endtask
  task automatic send_one(input logic [W-1:0] enc, input logic [W-1:0] exp);
    int n = 0;
    out_ready = 1;
    in_data = enc;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("ready_timeout", 32'(n < 100), 32'h1);
    step();
    in_valid = 0;
    chk("dec_valid", 32'(out_valid), 32'h1);
    chk("dec_data", 32'(out_data), 32'(exp));
    step();
  endtask
  initial begin
    int n, sent;
    bit acc;
    do_reset();
    send_one(8'h00, 8'h04);
    send_one(8'h04, 8'h00);
    send_one(8'h05, 8'hFF);
    send_one(8'hF4, 8'h10);
    do_reset();
    in_valid = 1;
    in_data = 8'h00;
    step();
    in_data = 8'h04;
    step();
    chk("bp_ready_drop", 32'(in_ready), 32'h0);
    chk("bp_hold", 32'(out_data), 32'h04);
    in_data = 8'h05;
    step();
    step();
    chk("bp_ready_low", 32'(in_ready), 32'h0);
    chk("bp_hold2", 32'(out_data), 32'h04);
    out_ready = 1;
    step();
    chk("bp_out1", 32'(out_data), 32'h00);
    step();
    in_valid = 0;
    chk("bp_out2", 32'(out_data), 32'hFF);
    step();
    chk("bp_empty", 32'(out_valid), 32'h0);
    chk("bp_cnt", 32'(byte_cnt), 32'd3);
    do_reset();
    out_ready = 1;
    n = 0;
    for (int x = 0; x < 256; x++) begin
      in_data = ~W'(x) + W'(OFF);
      in_valid = 1;
      if (!in_ready) n++;
      step();
    end
    in_valid = 0;
    step();
    chk("stream_stalls", 32'(n), 32'h0);
    chk("stream_cnt", 32'(byte_cnt), 32'd256);
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_valid = 0;
    chk("two_ready", 32'(in_ready), 32'h0);
    #2 rst_n = 0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_ready", 32'(in_ready), 32'h0);
    chk("async_cnt", 32'(byte_cnt), 32'h0);
    step();
    rst_n = 1;
    step();
    send_one(8'hF4, 8'h10);
    sent = 0;
    n = 0;
    while (sent < 10000 && n < 40000) begin
      if (!in_valid && $urandom_range(7) != 0) begin
        in_valid = 1;
        in_data = W'($urandom);
      end
      out_ready = $urandom_range(7) != 0;
      acc = in_valid && in_ready;
      step();
      n++;
      if (acc) begin
        sent++;
        in_valid = 0;
      end
    end
    chk("rand_timeout", 32'(sent), 32'd10000);
    in_valid = 0;
    out_ready = 1;
    repeat (4) step();
    chk("rand_drained", 32'(out_valid), 32'h0);
    in_valid = 1;
    n = 0;
    while (byte_cnt < 16'hFFFD && n < 70000) begin
      in_data = W'($urandom);
      step();
      n++;
    end
    in_valid = 0;
    step();
    chk("sat_pre", 32'(byte_cnt), 32'hFFFE);
    in_valid = 1;
    repeat (3) step();
    in_valid = 0;
    repeat (2) step();
    chk("sat_cnt", 32'(byte_cnt), 32'hFFFF);
    chk("sat_empty", 32'(out_valid), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xform_decode.md
XFORM_DECODE -- requirements
Module: xform_decode

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8: data width in bits.
REQ-002 The module SHALL take parameter OFFSET, default 5: the additive constant used by the encoding stage.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: upstream encoded word valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: decoder can accept a word.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: encoded word, enc = ~x + OFFSET.
REQ-008 The module SHALL have port out_valid, output, 1 bit: decoded word valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-010 The module SHALL have port out_data, output, WIDTH bits: decoded word.
REQ-011 The module SHALL have port byte_cnt, output, 16 bits: count of output transfers.

Function
REQ-012 Decode SHALL be out = ~(in_data - OFFSET), computed mod 2^WIDTH with wrap-around and no saturation, so that decode(~x + OFFSET) = x for all x.
REQ-013 An input transfer SHALL occur on a clock edge when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-014 Buffering SHALL be a 2-entry skid structure: a main register driving out_data and a skid register, with states EMPTY, ONE and TWO.
REQ-015 From EMPTY, an input transfer SHALL go to ONE (main <= decoded in_data); otherwise the state SHALL stay EMPTY.
REQ-016 From ONE, the transitions SHALL be:
- input transfer with no output transfer -> TWO (skid <= decoded word);
- output transfer with no input transfer -> EMPTY;
- both -> stay ONE (main <= decoded word);
- neither -> stay ONE.
REQ-017 From TWO, an output transfer SHALL go to ONE (main <= skid); in TWO no input transfer is possible.
REQ-018 out_valid SHALL be 1 exactly when the state is ONE or TWO.
REQ-019 in_ready SHALL be a flop loaded each cycle with (next state != TWO), so it has no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge N is on out_data with out_valid=1 after edge N when the buffer was EMPTY.
REQ-021 Sustained throughput SHALL be 1 word per cycle when out_ready is held at 1.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-023 Words SHALL be delivered in order, with no loss and no duplication.
REQ-024 byte_cnt SHALL increment by 1 on each output transfer and saturate at 0xFFFF.
REQ-025 in_valid asserted while in_ready=0 SHALL be ignored; upstream holds the word.

Reset
REQ-026 While rst_n=0, the outputs SHALL be: state EMPTY, out_valid=0, in_ready=0, out_data=0, byte_cnt=0; the skid register SHALL be 0.
REQ-027 in_ready SHALL rise at the first rising clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard buffered words immediately and asynchronously, with no output transfer completing.

Verification
REQ-029 Single words with out_ready=1 SHALL decode as follows, each 1 cycle after acceptance:
- in_data 0x00 -> out_data 0x04;
- 0x04 -> 0x00;
- 0x05 -> 0xFF;
- 0xF4 -> 0x10.
REQ-030 Backpressure: send 0x00, 0x04, 0x05 with out_ready=0 -> in_ready drops after the second accept, out_data holds 0x04; then raise out_ready -> outputs 0x04, 0x00, 0xFF in order, byte_cnt=3.
REQ-031 Streaming: send 256 back-to-back encoded words of x=0..255 with out_ready=1 -> no in_ready drop, outputs 0..255 in order, byte_cnt=256.
REQ-032 Random in_valid/out_ready toggling over 10,000 words -> scoreboard matches the encode inverse with no loss or duplication, and out_data is stable while stalled.
REQ-033 Assert rst_n=0 in state TWO -> out_valid=0, in_ready=0 and byte_cnt=0 immediately; after release, the next word 0xF4 -> 0x10.
REQ-034 Force byte_cnt near 0xFFFE and transfer 3 words -> byte_cnt ends at 0xFFFF.
